cache_miss_fsm: RTL
===================

# cache_miss_fsm

Registered miss-handling controller for the split I/D cache pair, parametrised in line length. It generates per-cycle control for both cache_2way instances and the RAM port, and owns the state and beat-counter registers, so no external state register is needed. Line refills are critical-word-first and paced by a RAM ready handshake.

## Interface
- WORDS_PER_LINE, 8: words per cache line; power of two, 2..16.
- WSEL_W, $clog2(WORDS_PER_LINE): width of word-select and counter fields.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ic_read / dc_read / dc_write  in  1 each  CPU requests.
- ic_hit, ic_valid, dc_hit, dc_valid, dc_dirty  in  1 each  cache_2way lookup results, same cycle.
- ic_word_sel_in / dc_word_sel_in  in  WSEL_W each  CPU word offsets.
- dc_byte_w_en_in  in  4  CPU store byte mask.
- ram_ready  in  1  RAM completed the current beat; ignored when ram_en=0.
- ic_enable, ic_cmp, ic_write, ic_valid_out  out  1 each  I-cache control.
- dc_enable, dc_cmp, dc_write, dc_valid_out  out  1 each  D-cache control.
- ic_word_sel / dc_word_sel  out  WSEL_W each  word addressed this cycle.
- ic_byte_w_en / dc_byte_w_en  out  4 each  byte write masks.
- ram_en, ram_write  out  1 each  RAM beat request / direction.
- ram_addr_sel  out  2  00 I-fill, 01 D-fill, 11 D-writeback.
- stall  out  1  CPU must hold its request.
- status  out  3  current state. counter  out  WSEL_W  beats done.

## Operation
- States (encoding): NORMAL=0, IC_MISS=1, DC_MISS=2, DC_MISS_D=3, DOUBLE_MISS=4, DOUBLE_MISS_D=5. Codes 6/7 decode as NORMAL and move to NORMAL.
- NORMAL:
  - ic_enable=ic_read, dc_enable=dc_read|dc_write, cmp=1, dc_write=dc_write, masks pass through, ram_en=0.
  - Miss classification: dmiss = dc_enable & !(dc_hit&dc_valid); imiss = ic_read & !(ic_hit&ic_valid).
  - Next state: dmiss&imiss gives DOUBLE_MISS_D if dc_dirty, else DOUBLE_MISS. dmiss alone gives DC_MISS_D or DC_MISS by dc_dirty. imiss alone gives IC_MISS. Otherwise NORMAL.
  - On leaving NORMAL, latch ic_base=ic_word_sel_in and dc_base=dc_word_sel_in. counter=0.
- Fill/writeback states:
  - Word select = base + counter, modulo WORDS_PER_LINE (wraps).
  - Beat completes when ram_en & ram_ready. On completion counter+1; the last beat (counter=WORDS_PER_LINE-1) resets counter to 0 and takes the exit.
  - Cache write strobes (ic_write/dc_write, mask 4'b1111) are asserted only in the completing cycle.
- IC_MISS: write I-cache, ram_addr_sel=00, ram_write=0. Exit to NORMAL.
- DC_MISS: write D-cache, ram_addr_sel=01. Exit to NORMAL.
- DC_MISS_D: read D-cache (cmp=0), ram_write=1, ram_addr_sel=11. Writeback always starts at word 0 and ignores dc_base. Exit to DC_MISS.
- DOUBLE_MISS_D: same actions as DC_MISS_D. Exit to DOUBLE_MISS.
- DOUBLE_MISS: same actions as IC_MISS. Exit to DC_MISS.
- stall = (status!=NORMAL) | dmiss | imiss.
- valid_out outputs are always 1.

## Timing
- Outputs are combinational from registered status/counter/base, plus NORMAL-state inputs.
- Exactly one state transition per clk edge.
- Minimum miss latency with ram_ready tied high (N=WORDS_PER_LINE):
  - IC_MISS: N cycles.
  - DC_MISS: N cycles.
  - dirty D-miss: 2N cycles.
  - DOUBLE_MISS_D: 3N cycles.
- ram_ready low holds state, counter and all outputs unchanged; ram_en stays asserted (RAM must see a stable request).
- Reset (rst_n low at an edge, including mid-miss):
  - Next cycle: status=NORMAL, counter=0, bases=0.
  - While rst_n is low, all enables, writes, ram_en and stall are forced 0; word selects and masks are 0.
  - An interrupted writeback is abandoned and not resumed.

## Configuration
- CACHE_IFETCH_DC_FWD_EN defined:
  - In IC_MISS/DOUBLE_MISS, D-cache is enabled with cmp=1, write=0, word = ic_base+counter.
  - If dc_hit&dc_valid, ram_en=0 and the beat completes unconditionally; the D-cache word is used for coherence.
- Undefined: dc_enable=0 in those states and every beat uses RAM.

## Test plan
- N=8, ram_ready=1, ic_read with ic_word_sel_in=5 misses -> IC_MISS for 8 cycles, ic_word_sel 5,6,7,0..4, back to NORMAL, stall low next cycle.
- dc_write miss, dc_dirty=1, dc_word_sel_in=2 -> 8 writeback beats (ram_write=1, sel 11, words 0..7), then 8 fill beats from word 2, total 16 cycles.
- Simultaneous I+D miss, dirty -> status sequence 5,4,2,0 with 8 beats each.
- ram_ready toggling 1,0,1,0 during DC_MISS -> counter advances only on ready cycles, dc_write pulses only then, fill takes 16 cycles.
- rst_n low at counter=3 in DOUBLE_MISS_D -> next cycle status=0, counter=0, ram_en=0.
- With CACHE_IFETCH_DC_FWD_EN, IC_MISS while dc_hit=dc_valid=1 and ram_ready=0 -> ram_en=0, fill completes in 8 cycles. Without the macro, the same stimulus stalls indefinitely.

Source files
------------

// File: rtl/cache_miss_fsm_if.sv
// Bundle of CPU request, cache lookup, cache control and RAM handshake signals
// between the miss controller (master) and the cache/RAM fabric (slave).
interface cache_miss_fsm_if #(
   parameter int WORDS_PER_LINE = 8
);
   localparam int WSEL_W = $clog2(WORDS_PER_LINE);

   // CPU requests; dc_write_in is the store request, dc_write the D-cache strobe
   logic              ic_read;
   logic              dc_read;
   logic              dc_write_in;
   logic              ic_hit;
   logic              ic_valid;
   logic              dc_hit;
   logic              dc_valid;
   logic              dc_dirty;
   logic [WSEL_W-1:0] ic_word_sel_in;
   logic [WSEL_W-1:0] dc_word_sel_in;
   logic [3:0]        dc_byte_w_en_in;
   logic              ram_ready;

   logic              ic_enable;
   logic              ic_cmp;
   logic              ic_write;
   logic              ic_valid_out;
   logic              dc_enable;
   logic              dc_cmp;
   logic              dc_write;
   logic              dc_valid_out;
   logic [WSEL_W-1:0] ic_word_sel;
   logic [WSEL_W-1:0] dc_word_sel;
   logic [3:0]        ic_byte_w_en;
   logic [3:0]        dc_byte_w_en;
   logic              ram_en;
   logic              ram_write;
   logic [1:0]        ram_addr_sel;
   logic              stall;
   logic [2:0]        status;
   logic [WSEL_W-1:0] counter;

   modport master (
      input  ic_read, dc_read, dc_write_in, ic_hit, ic_valid, dc_hit, dc_valid,
             dc_dirty, ic_word_sel_in, dc_word_sel_in, dc_byte_w_en_in, ram_ready,
      output ic_enable, ic_cmp, ic_write, ic_valid_out, dc_enable, dc_cmp,
             dc_write, dc_valid_out, ic_word_sel, dc_word_sel, ic_byte_w_en,
             dc_byte_w_en, ram_en, ram_write, ram_addr_sel, stall, status, counter
   );

   modport slave (
      output ic_read, dc_read, dc_write_in, ic_hit, ic_valid, dc_hit, dc_valid,
             dc_dirty, ic_word_sel_in, dc_word_sel_in, dc_byte_w_en_in, ram_ready,
      input  ic_enable, ic_cmp, ic_write, ic_valid_out, dc_enable, dc_cmp,
             dc_write, dc_valid_out, ic_word_sel, dc_word_sel, ic_byte_w_en,
             dc_byte_w_en, ram_en, ram_write, ram_addr_sel, stall, status, counter
   );
endinterface

// File: rtl/cache_miss_fsm.sv
// Miss controller for the split I/D cache pair: critical-word-first refills and
// dirty-line writebacks paced by ram_ready. Option macro: CACHE_IFETCH_DC_FWD_EN.
module cache_miss_fsm #(
   parameter int WORDS_PER_LINE = 8
) (
   input logic             clk,
   input logic             rst_n,
   cache_miss_fsm_if.master bus
);
   localparam int WSEL_W = $clog2(WORDS_PER_LINE);
   localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {
      NORMAL        = 3'd0,
      IC_MISS       = 3'd1,
      DC_MISS       = 3'd2,
      DC_MISS_D     = 3'd3,
      DOUBLE_MISS   = 3'd4,
      DOUBLE_MISS_D = 3'd5
   } state_t;

   state_t            status_reg;
   logic [WSEL_W-1:0] counter_reg;
   logic [WSEL_W-1:0] ic_base_reg;
   logic [WSEL_W-1:0] dc_base_reg;

   logic              imiss;
   logic              dmiss;
   logic              ram_req;
   logic              fwd_hit;
   logic              beat_done;
   logic [WSEL_W-1:0] ic_fill_word;
   logic [WSEL_W-1:0] dc_fill_word;
   state_t            exit_state;

   assign bus.status       = status_reg;
   assign bus.counter      = counter_reg;
   assign bus.ic_valid_out = 1'b1;
   assign bus.dc_valid_out = 1'b1;

   always_comb begin
      imiss        = bus.ic_read & ~(bus.ic_hit & bus.ic_valid);
      dmiss        = (bus.dc_read | bus.dc_write_in) & ~(bus.dc_hit & bus.dc_valid);
      ic_fill_word = ic_base_reg + counter_reg;
      dc_fill_word = dc_base_reg + counter_reg;
      ram_req      = 1'b0;
      fwd_hit      = 1'b0;
      beat_done    = 1'b0;
      exit_state   = NORMAL;

      bus.ic_enable    = 1'b0;
      bus.ic_cmp       = 1'b0;
      bus.ic_write     = 1'b0;
      bus.ic_word_sel  = '0;
      bus.ic_byte_w_en = 4'b0000;
      bus.dc_enable    = 1'b0;
      bus.dc_cmp       = 1'b0;
      bus.dc_write     = 1'b0;
      bus.dc_word_sel  = '0;
      bus.dc_byte_w_en = 4'b0000;
      bus.ram_write    = 1'b0;
      bus.ram_addr_sel = 2'b00;
      bus.stall        = 1'b1;

      case (status_reg)
         IC_MISS, DOUBLE_MISS: begin
            bus.ic_enable   = 1'b1;
            bus.ic_word_sel = ic_fill_word;
            ram_req         = 1'b1;
`ifdef CACHE_IFETCH_DC_FWD_EN
            // A copy of the fill word held in the D-cache replaces the RAM beat
            bus.dc_enable   = 1'b1;
            bus.dc_cmp      = 1'b1;
            bus.dc_word_sel = ic_fill_word;
            fwd_hit         = bus.dc_hit & bus.dc_valid;
            ram_req         = ~fwd_hit;
`endif
            beat_done        = fwd_hit | (ram_req & bus.ram_ready);
            bus.ic_write     = beat_done;
            bus.ic_byte_w_en = {4{beat_done}};
            exit_state       = (status_reg == IC_MISS) ? NORMAL : DC_MISS;
         end
         DC_MISS: begin
            bus.dc_enable    = 1'b1;
            bus.dc_word_sel  = dc_fill_word;
            ram_req          = 1'b1;
            beat_done        = bus.ram_ready;
            bus.dc_write     = beat_done;
            bus.dc_byte_w_en = {4{beat_done}};
            bus.ram_addr_sel = 2'b01;
            exit_state       = NORMAL;
         end
         DC_MISS_D, DOUBLE_MISS_D: begin
            // Writeback streams the whole victim line from word 0
            bus.dc_enable    = 1'b1;
            bus.dc_word_sel  = counter_reg;
            ram_req          = 1'b1;
            beat_done        = bus.ram_ready;
            bus.ram_write    = 1'b1;
            bus.ram_addr_sel = 2'b11;
            exit_state       = (status_reg == DC_MISS_D) ? DC_MISS : DOUBLE_MISS;
         end
         default: begin
            bus.ic_enable    = bus.ic_read;
            bus.ic_cmp       = 1'b1;
            bus.ic_word_sel  = bus.ic_word_sel_in;
            bus.dc_enable    = bus.dc_read | bus.dc_write_in;
            bus.dc_cmp       = 1'b1;
            bus.dc_write     = bus.dc_write_in;
            bus.dc_word_sel  = bus.dc_word_sel_in;
            bus.dc_byte_w_en = bus.dc_byte_w_en_in;
            bus.stall        = imiss | dmiss;
         end
      endcase

      bus.ram_en = ram_req;

      if (!rst_n) begin
         bus.ic_enable    = 1'b0;
         bus.ic_write     = 1'b0;
         bus.ic_word_sel  = '0;
         bus.ic_byte_w_en = 4'b0000;
         bus.dc_enable    = 1'b0;
         bus.dc_write     = 1'b0;
         bus.dc_word_sel  = '0;
         bus.dc_byte_w_en = 4'b0000;
         bus.ram_en       = 1'b0;
         bus.ram_write    = 1'b0;
         bus.stall        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         status_reg  <= NORMAL;
         counter_reg <= '0;
         ic_base_reg <= '0;
         dc_base_reg <= '0;
      end else begin
         case (status_reg)
            IC_MISS, DC_MISS, DC_MISS_D, DOUBLE_MISS, DOUBLE_MISS_D: begin
               if (beat_done) begin
                  if (counter_reg == LAST_BEAT) begin
                     counter_reg <= '0;
                     status_reg  <= exit_state;
                  end else begin
                     counter_reg <= counter_reg + 1'b1;
                  end
               end
            end
            default: begin
               counter_reg <= '0;
               status_reg  <= NORMAL;
               if (imiss | dmiss) begin
                  ic_base_reg <= bus.ic_word_sel_in;
                  dc_base_reg <= bus.dc_word_sel_in;
                  if (imiss & dmiss)
                     status_reg <= bus.dc_dirty ? DOUBLE_MISS_D : DOUBLE_MISS;
                  else if (dmiss)
                     status_reg <= bus.dc_dirty ? DC_MISS_D : DC_MISS;
                  else
                     status_reg <= IC_MISS;
               end
            end
         endcase
      end
   end
endmodule
